branch_pc_ctrl: RTL

BRANCH_PC_CTRL -- requirements
Module: branch_pc_ctrl

---
 rtl/branch_pc_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/branch_pc_ctrl.sv
// branch_pc_ctrl: program counter sequencer with a small branch-target table.
// The FSM steps through IDLE -> RUN -> HALTED. In RUN the PC advances by one
// each cycle, or it jumps to an absolute target held in the table.
module branch_pc_ctrl #(
    parameter int PC_W       = 10,
    parameter int LUT_AW     = 5,
    parameter int START_ADDR = 0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic              HALT_REQ,
    input  logic              JUMP,
    input  logic              BRANCH,
    input  logic              ZERO,
    input  logic [LUT_AW-1:0] TARGET_SEL,
    input  logic              LUT_WE,
    input  logic [LUT_AW-1:0] LUT_WADDR,
    input  logic [PC_W-1:0]   LUT_WDATA,
    output logic [PC_W-1:0]   PC,
    output logic              RUNNING,
    output logic              DONE
);

    localparam int              LUT_N    = 1 << LUT_AW;
    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t          state;
    logic [PC_W-1:0] lut [LUT_N];
    logic [PC_W-1:0] target;

    // Combinational read of the stored contents. A write in the same cycle
    // lands at the edge, so a jump that cycle still sees the old entry.
    assign target = lut[TARGET_SEL];

    // Branch-target table: cleared on reset, written in any state.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            for (int i = 0; i < LUT_N; i++) begin
                lut[i] <= '0;
            end
        end else if (LUT_WE) begin
            lut[LUT_WADDR] <= LUT_WDATA;
        end
    end

    // Sequencer FSM. PC and the status flags are registered alongside the state.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state   <= S_IDLE;
            PC      <= START_PC;
            RUNNING <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state   <= S_RUN;
                        PC      <= START_PC;
                        RUNNING <= 1'b1;
                        DONE    <= 1'b0;
                    end
                end
                S_RUN: begin
                    // Priority: halt, jump, taken branch, sequential.
                    if (HALT_REQ) begin
                        state   <= S_HALTED;
                        RUNNING <= 1'b0;
                        DONE    <= 1'b1;
                    end else if (JUMP || (BRANCH && ZERO)) begin
                        PC <= target;
                    end else begin
                        PC <= PC + 1'b1;
                    end
                end
                S_HALTED: begin
                    if (START) begin
                        state   <= S_RUN;
                        PC      <= START_PC;
                        RUNNING <= 1'b1;
                        DONE    <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    PC      <= START_PC;
                    RUNNING <= 1'b0;
                    DONE    <= 1'b0;
                end
            endcase
        end
    end

endmodule
